// File: rtl/road_tile_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : road_tile_seq_pkg
//  Brief    : Shared constants and types for the road tile sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package road_tile_seq_pkg;

  // First scanline of the road band; low 5 bits are the Y origin.
  localparam logic [8:0] ROAD_TOP    = 9'd192;
  localparam int         TILE_W      = 16;
  localparam int         ROAD_H      = 32;
  localparam int         MAP_IDX_W   = 5;
  localparam int         MAP_ENTRY_W = 3;
  localparam int         MIRROR_BIT  = 2;
  localparam int         SPR_LSB     = 0;
  localparam int         PIX_W       = $clog2(TILE_W);

  // One map entry: {mirror, sprite_number[1:0]}.
  typedef logic [MAP_ENTRY_W-1:0] map_entry_t;

  // Map index of the tile containing scrolled position p.
  function automatic logic [MAP_IDX_W-1:0] tile_idx(input logic [8:0] p);
    return p[8:PIX_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/road_tile_seq_map_ram.sv
`default_nettype none
// ============================================================================
//  Module   : road_map_ram
//  Brief    : 32x3 road map register file; synchronous write, combinational
//             read. A read of the address being written returns old data.
//  Revision : 1.0 - initial release
// ============================================================================
module road_map_ram
  import road_tile_seq_pkg::*;
#(
  parameter int MAP_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic [MAP_IDX_W-1:0] wr_addr_i,
  input  map_entry_t           wr_data_i,
  input  logic [MAP_IDX_W-1:0] rd_addr_i,
  output map_entry_t           rd_data_o
);

  map_entry_t mem_q [MAP_DEPTH];

  // Map storage: cleared on reset, written on the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/road_tile_seq.sv
`default_nettype none
// ============================================================================
//  Module   : road_tile_seq
//  Brief    : Tile-select front end for the road sprite generator. Scrolls a
//             32-entry road map once per frame and presents sprite, mirror
//             and a 16-px aligned X origin one pixel ahead of H_pos.
//  Revision : 1.0 - initial release
// ============================================================================
module road_tile_seq
#(
  parameter logic [8:0] ROAD_TOP  = road_tile_seq_pkg::ROAD_TOP,
  parameter int         MAP_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  H_pos,
  input  logic [8:0]  V_pos,
  input  logic        enable,
  input  logic [3:0]  speed,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [2:0]  wr_data,
  output logic [1:0]  sprite_number,
  output logic [8:0]  X,
  output logic [4:0]  Y,
  output logic        mirror,
  output logic        road_active,
  output logic [15:0] distance
);

  import road_tile_seq_pkg::MAP_IDX_W;
  import road_tile_seq_pkg::ROAD_H;
  import road_tile_seq_pkg::PIX_W;
  import road_tile_seq_pkg::MIRROR_BIT;
  import road_tile_seq_pkg::SPR_LSB;
  import road_tile_seq_pkg::map_entry_t;
  import road_tile_seq_pkg::tile_idx;

  logic [8:0]     prev_v_q;
  logic [8:0]     scroll_q, scroll_d;
  logic [15:0]    dist_q, dist_d;
  logic [8:0]     x_q, x_d;
  map_entry_t     hold_q, hold_d;
  logic           first_q;
  logic           ract_q, ract_d;

  logic [8:0]     w_hn;
  logic [8:0]     w_p;
  logic [8:0]     w_band_off;
  logic           w_frame;
  logic [MAP_IDX_W-1:0] w_rd_addr;
  map_entry_t     w_rd_data;

  assign w_rd_addr = tile_idx(w_p);

  road_map_ram #(
    .MAP_DEPTH (MAP_DEPTH)
  ) u_map (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (w_rd_addr),
    .rd_data_o (w_rd_data)
  );

  // Look-ahead position, per-frame scroll update, tile latch and band decode.
  always_comb begin
    w_hn       = H_pos + 9'd1;
    w_p        = w_hn + scroll_q;
    x_d        = w_hn - {{(9-PIX_W){1'b0}}, w_p[PIX_W-1:0]};
    w_frame    = (V_pos == 9'd0) && (prev_v_q != 9'd0);
    w_band_off = V_pos - ROAD_TOP;
    ract_d     = w_band_off < 9'(ROAD_H);
    scroll_d   = scroll_q;
    dist_d     = dist_q;
    hold_d     = hold_q;
    if (w_frame && enable) begin
      scroll_d = scroll_q + {5'd0, speed};
      if ((scroll_d[8:PIX_W] != scroll_q[8:PIX_W]) && (dist_q != 16'hFFFF)) begin
        dist_d = dist_q + 16'd1;
      end
    end
    // Only latch at a tile boundary so mid-tile map writes never tear.
    if ((w_p[PIX_W-1:0] == '0) || first_q) begin
      hold_d = w_rd_data;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_v_q <= '0;
      scroll_q <= '0;
      dist_q   <= '0;
      x_q      <= '0;
      hold_q   <= '0;
      first_q  <= 1'b1;
      ract_q   <= 1'b0;
    end else begin
      prev_v_q <= V_pos;
      scroll_q <= scroll_d;
      dist_q   <= dist_d;
      x_q      <= x_d;
      hold_q   <= hold_d;
      first_q  <= 1'b0;
      ract_q   <= ract_d;
    end
  end

  assign X             = x_q;
  assign Y             = ROAD_TOP[4:0];
  assign sprite_number = hold_q[SPR_LSB +: 2];
  assign mirror        = hold_q[MIRROR_BIT];
  assign road_active   = ract_q;
  assign distance      = dist_q;

endmodule
`default_nettype wire

// File: tb/tb_road_tile_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_road_tile_seq
//  Brief    : Self-checking bench for road_tile_seq with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_road_tile_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  H_pos = '0;
  logic [8:0]  V_pos = '0;
  logic        enable = 1'b0;
  logic [3:0]  speed = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [2:0]  wr_data = '0;
  logic [1:0]  sprite_number;
  logic [8:0]  X;
  logic [4:0]  Y;
  logic        mirror;
  logic        road_active;
  logic [15:0] distance;

  road_tile_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .H_pos         (H_pos),
    .V_pos         (V_pos),
    .enable        (enable),
    .speed         (speed),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .sprite_number (sprite_number),
    .X             (X),
    .Y             (Y),
    .mirror        (mirror),
    .road_active   (road_active),
    .distance      (distance)
  );

  always #5 clk = ~clk;

  // Behavioural model: scroll position in pixels, tile count, displayed entry.
  int m_map [32];
  int m_scroll, m_dist, m_hold, m_prevv, m_x, m_ract;
  bit m_first;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = 0;
    m_scroll = 0; m_dist = 0; m_hold = 0; m_prevv = 0; m_x = 0; m_ract = 0;
    m_first = 1'b1;
  endtask

  task automatic check_all();
    chk("X", int'(X), m_x);
    chk("sprite_number", int'(sprite_number), m_hold % 4);
    chk("mirror", int'(mirror), m_hold / 4);
    chk("road_active", int'(road_active), m_ract);
    chk("distance", int'(distance), m_dist);
    chk("Y", int'(Y), 192 % 32);
  endtask

  // Predict one clock from the inputs currently driven, clock, then compare.
  task automatic tick();
    int h, v, hn, p, nx, nh, ns, nd, nr;
    h  = int'(H_pos);
    v  = int'(V_pos);
    hn = (h + 1) % 512;
    p  = (hn + m_scroll) % 512;
    nx = (hn - (p % 16) + 512) % 512;
    nh = ((p % 16) == 0 || m_first) ? m_map[p / 16] : m_hold;
    ns = m_scroll;
    nd = m_dist;
    if (v == 0 && m_prevv != 0 && enable) begin
      ns = (m_scroll + int'(speed)) % 512;
      if ((ns / 16) != (m_scroll / 16) && nd < 65535) nd++;
    end
    nr = (((v + 512 - 192) % 512) < 32) ? 1 : 0;
    if (wr_en) m_map[int'(wr_addr)] = int'(wr_data);
    @(posedge clk);
    #1;
    m_x = nx; m_hold = nh; m_scroll = ns; m_dist = nd; m_ract = nr;
    m_prevv = v; m_first = 1'b0;
    check_all();
  endtask

  task automatic frame();
    V_pos = 9'd261;
    tick();
    V_pos = 9'd0;
    tick();
  endtask

  // Assert reset in the middle of a cycle and check outputs immediately.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset.
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Build up some state, then reset mid-line.
    speed = 4'd5; enable = 1'b1; V_pos = 9'd50;
    for (int i = 0; i < 3; i++) frame();
    V_pos = 9'd50;
    for (int i = 0; i < 10; i++) begin H_pos = 9'(i * 7); tick(); end
    do_reset();
    chk("rst_X", int'(X), 0);
    chk("rst_distance", int'(distance), 0);
    chk("rst_road_active", int'(road_active), 0);

    // Map write with scroll_x = 0, then sweep across tile 3.
    V_pos = 9'd100;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 3'b110;
    tick();
    wr_en = 1'b0;
    for (int h = 40; h < 64; h++) begin
      H_pos = 9'(h);
      tick();
      if (h == 47) begin
        chk("tile3_X", int'(X), 48);
        chk("tile3_sprite", int'(sprite_number), 2);
        chk("tile3_mirror", int'(mirror), 1);
      end
      if (h >= 47) chk("tile3_window", (((h + 1) - int'(X) + 512) % 512) < 16 ? 1 : 0, 1);
    end

    // Scroll: four frames at speed 7 -> scroll 28, one tile crossed.
    speed = 4'd7;
    for (int i = 0; i < 4; i++) frame();
    V_pos = 9'd100; H_pos = 9'd0;
    tick();
    chk("scroll_X", int'(X), 500);
    chk("scroll_distance", int'(distance), 1);

    // Wrap: scroll up to 510 with speed 15 (34 frames, 31 tiles).
    do_reset();
    V_pos = 9'd100;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 3'b101;
    tick();
    wr_en = 1'b0;
    speed = 4'd15;
    for (int i = 0; i < 34; i++) frame();
    V_pos = 9'd100; H_pos = 9'd1;
    tick();
    chk("wrap_X", int'(X), 2);
    chk("wrap_sprite", int'(sprite_number), 1);
    chk("wrap_mirror", int'(mirror), 1);
    chk("wrap_distance", int'(distance), 31);

    // Collision: write map[5] on the cycle that latches it (H=81 -> p=80).
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 3'b001;
    H_pos = 9'd10;
    tick();
    H_pos = 9'd81; wr_data = 3'b011;
    tick();
    wr_en = 1'b0;
    chk("coll_old_sprite", int'(sprite_number), 1);
    chk("coll_old_mirror", int'(mirror), 0);
    for (int k = 1; k <= 512; k++) begin
      H_pos = 9'((81 + k) % 512);
      tick();
    end
    chk("coll_new_sprite", int'(sprite_number), 3);
    chk("coll_new_mirror", int'(mirror), 0);

    // Road band edges, one cycle late.
    V_pos = 9'd191; tick(); chk("band_191", int'(road_active), 0);
    V_pos = 9'd192; tick(); chk("band_192", int'(road_active), 1);
    V_pos = 9'd223; tick(); chk("band_223", int'(road_active), 1);
    V_pos = 9'd224; tick(); chk("band_224", int'(road_active), 0);

    // Scrolling frozen while disabled.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) frame();
    chk("frozen_distance", int'(distance), 31);
    V_pos = 9'd100; H_pos = 9'd1;
    tick();
    chk("frozen_X", int'(X), 2);

    // Randomised traffic against the model, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      H_pos   = 9'($urandom_range(0, 511));
      V_pos   = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 300));
      enable  = ($urandom_range(0, 3) != 0);
      speed   = 4'($urandom_range(0, 15));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = 3'($urandom_range(0, 7));
      tick();
      if (i == 1500) begin
        wr_en = 1'b0;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
